stack_controller: RTL
=====================

# stack_controller

Hardware call stack serving the Fibonacci controller's `pushSig`/`popSig` requests and answering with `readySig`. It stores one recursion frame per entry: `n`, `flag` and the partial result `res`. It sits directly beside the Fibonacci controller: the controller pushes a frame before descending and pops frames to resume. Each access is a multi-cycle request/ready handshake, so the controller's wait states (`START`, `PUSHBF`, `PUSHAF`) hold their request until `readySig` is seen.

## Interface
- `DATA_W`, 8, width of each frame field (`n`, `flag`, `res`)
- `ADDR_W`, 4, stack address width; depth = 2**`ADDR_W` frames
- `clk`  in  1  system clock; all state updates on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `pushSig`  in  1  push request; level, held until `readySig`
- `popSig`  in  1  pop request; level, held until `readySig`
- `n_in`, `flag_in`, `res_in`  in  `DATA_W` each  frame to push; sampled when the push is accepted in `IDLE`
- `readySig`  out  1  one-cycle pulse; the requested operation has completed
- `n_out`, `flag_out`, `res_out`  out  `DATA_W` each  last popped frame; registered, held until the next pop
- `count`  out  `ADDR_W`+1  frames currently stored (0..2**`ADDR_W`)
- `empty`, `full`  out  1  `count`==0 / `count`==2**`ADDR_W`
- `overflow`, `underflow`  out  1  sticky error flags
- `max_depth`  out  `ADDR_W`+1  high-water mark (see Configuration)

## Operation
- Storage: 2**`ADDR_W` x 3*`DATA_W` register array, frame packed {n,flag,res}.
- Stack pointer `sp` (`ADDR_W`+1 bits) = `count`; points at the next free slot.
- FSM states: `IDLE`, `WRITE`, `READ`, `ACK`.
  - `IDLE`: `pushSig` -> `WRITE`, latching `n_in`/`flag_in`/`res_in`; else `popSig` -> `READ`; else stay.
  - Both requests high in `IDLE`: push wins; pop is served on a later `IDLE` cycle if still held.
  - `WRITE`: if not full, mem[sp] <= latched frame and sp <= sp+1. If full, no write, sp unchanged, `overflow` <= 1. Always -> `ACK`.
  - `READ`: if not empty, outputs <= mem[sp-1] and sp <= sp-1. If empty, outputs <= 0, sp unchanged, `underflow` <= 1. Always -> `ACK`.
  - `ACK`: `readySig`=1 -> `IDLE`.
- Errors still acknowledge, so the requester never hangs. `overflow`/`underflow` clear only on `rst`.
- Requester must drop its request on the edge after it samples `readySig` high. A request still high in `IDLE` after `ACK` is treated as a new operation.
- Reset values: state `IDLE`; `sp`, `readySig`, all `*_out`, `overflow`, `underflow` and `max_depth` = 0; `empty`=1, `full`=0. Memory contents are not cleared and are don't-care.
- Reset mid-operation aborts it with no `readySig`; a pending write is discarded.

## Timing
- Request seen high at edge E0 in `IDLE` -> `WRITE`/`READ` executes at edge E1 -> `readySig` high during the cycle after E1, i.e. between E1 and E2.
- Latency from request sample to `readySig`: 2 cycles; throughput: one operation per 3 cycles.
- `n_out`/`flag_out`/`res_out` and `count` are valid in the same cycle `readySig` is high.
- `empty`/`full` are combinational from `sp`.
- Inputs are sampled only in `IDLE`; input changes during `WRITE`/`READ`/`ACK` are ignored.

## Configuration
- `STACK_WATERMARK_EN` defined:
  - `max_depth` register updates to `sp`+1 in `WRITE` when a successful push makes `sp`+1 exceed it.
  - It clears on `rst` only.
- Not defined: the register is not built and `max_depth` is tied to 0.

## Test plan
- Reset, then push {n=5,flag=1,res=0} -> `readySig` pulses exactly 2 cycles after the request edge; `count`=1, `empty`=0.
- Push {5,1,0}, {4,1,0}, {3,2,7}, then three pops -> outputs {3,2,7}, {4,1,0}, {5,1,0} in order; `count` ends at 0 and `empty`=1.
- Push 17 frames with `ADDR_W`=4 -> 17th push acknowledged with `overflow`=1 and `count`=16; the next pop returns frame 16.
- Pop when empty -> `readySig` pulses, outputs=0, `underflow`=1, `count`=0.
- `pushSig` and `popSig` both high in `IDLE` -> push completes first (`count` 0->1); pop held high then returns the pushed frame (`count` 1->0).
- Assert `rst` during `WRITE` -> no `readySig`, `count`=0, flags 0. With `STACK_WATERMARK_EN`, 3 pushes/2 pops/1 push -> `max_depth`=3; without it, `max_depth`=0.

Source files
------------

// File: rtl/stack_controller.sv
// stack_controller: hardware call stack for the Fibonacci controller.
// Each entry holds one recursion frame {n, flag, res}. Every push/pop is a
// request/ready handshake: request seen in IDLE, executed in WRITE/READ,
// acknowledged with a one-cycle readySig pulse in ACK.
// Optional feature: define STACK_WATERMARK_EN to build the max_depth
// high-water-mark register; otherwise max_depth is tied to 0.
module stack_controller #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pushSig,
  input  logic              popSig,
  input  logic [DATA_W-1:0] n_in,
  input  logic [DATA_W-1:0] flag_in,
  input  logic [DATA_W-1:0] res_in,
  output logic              readySig,
  output logic [DATA_W-1:0] n_out,
  output logic [DATA_W-1:0] flag_out,
  output logic [DATA_W-1:0] res_out,
  output logic [ADDR_W:0]   count,
  output logic              empty,
  output logic              full,
  output logic              overflow,
  output logic              underflow,
  output logic [ADDR_W:0]   max_depth
);

  localparam int FRAME_W = 3 * DATA_W;
  localparam int DEPTH   = 1 << ADDR_W;

  localparam logic [ADDR_W:0]   DEPTH_P = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   ONE_P   = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] ONE_A   = ADDR_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    ACK   = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [FRAME_W-1:0] mem [DEPTH];
  logic [FRAME_W-1:0] frame_q;   // frame latched when a push is accepted
  logic [FRAME_W-1:0] rd_frame;  // top-of-stack entry
  logic [ADDR_W:0]    sp;        // next free slot == number of frames
  logic [ADDR_W-1:0]  wr_addr;
  logic [ADDR_W-1:0]  rd_addr;

  assign wr_addr  = sp[ADDR_W-1:0];
  assign rd_addr  = sp[ADDR_W-1:0] - ONE_A;
  assign rd_frame = mem[rd_addr];

  assign count    = sp;
  assign empty    = (sp == '0);
  assign full     = (sp == DEPTH_P);
  assign readySig = (state_q == ACK);

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; push has priority over pop when both are requested.
  // NOTE: state_d gets a default before the case so no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (pushSig)     state_d = WRITE;
        else if (popSig) state_d = READ;
      end
      WRITE:   state_d = ACK;
      READ:    state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Stack pointer, latched push frame, popped outputs and sticky error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      sp        <= '0;
      frame_q   <= '0;
      n_out     <= '0;
      flag_out  <= '0;
      res_out   <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (state_q == IDLE && pushSig) frame_q <= {n_in, flag_in, res_in};

      if (state_q == WRITE) begin
        if (!full) sp       <= sp + ONE_P;
        else       overflow <= 1'b1;
      end

      if (state_q == READ) begin
        if (!empty) begin
          {n_out, flag_out, res_out} <= rd_frame;
          sp                         <= sp - ONE_P;
        end else begin
          {n_out, flag_out, res_out} <= '0;
          underflow                  <= 1'b1;
        end
      end
    end
  end

  // Frame storage write port; a reset during WRITE suppresses the write.
  // NOTE: the array is deliberately not reset -- slots above sp are never
  // read, and leaving it reset-free lets it map onto plain storage.
  always_ff @(posedge clk) begin
    if (!rst && state_q == WRITE && !full) mem[wr_addr] <= frame_q;
  end

`ifdef STACK_WATERMARK_EN
  // High-water mark: deepest stack occupancy since the last reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      max_depth <= '0;
    end else if (state_q == WRITE && !full && (sp + ONE_P) > max_depth) begin
      max_depth <= sp + ONE_P;
    end
  end
`else
  assign max_depth = '0;
`endif

endmodule
